// File: rtl/ddsm_pkg.sv
// Shared DDSM definitions: MASH order encodings, combiner width and the
// divider-modulus saturation helpers.
package ddsm_pkg;

  localparam int Y_WIDTH = 4;

  typedef enum logic [1:0] {
    ORDER_1 = 2'd1,
    ORDER_2 = 2'd2,
    ORDER_3 = 2'd3
  } order_e;

  // Raw order 0 is not a legal cascade depth and behaves as a first-order modulator.
  function automatic order_e decode_order(input logic [1:0] raw);
    case (raw)
      2'd2:    return ORDER_2;
      2'd3:    return ORDER_3;
      default: return ORDER_1;
    endcase
  endfunction

  function automatic int clamp_div(input int s, input int max_v);
    if (s < 0)          return 0;
    else if (s > max_v) return max_v;
    else                return s;
  endfunction

  function automatic logic is_sat(input int s, input int max_v);
    return (s < 0) || (s > max_v);
  endfunction

endpackage

// File: rtl/ddsm_delay.sv
// Enabled depth-N, width-1 shift register used to time-align EFM carries.
module ddsm_delay #(
  parameter int DEPTH = 1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_en,
  input  logic i_d,
  output logic o_q
);

  logic [DEPTH-1:0] sr;

  // NOTE: this is a handful of flops, not a RAM, so it takes a reset; a
  // mid-stream reset must not leak stale carries into the refilled output.
  if (DEPTH == 1) begin : g_single
    always_ff @(posedge i_clk) begin
      if (i_rst)     sr <= '0;
      else if (i_en) sr <= i_d;
    end
  end else begin : g_multi
    always_ff @(posedge i_clk) begin
      if (i_rst)     sr <= '0;
      else if (i_en) sr <= {sr[DEPTH-2:0], i_d};
    end
  end

  assign o_q = sr[DEPTH-1];

endmodule

// File: rtl/mash_ncl.sv
// MASH 1-1-1 noise-cancellation combiner: aligns the EFM carries, applies the
// (1-z^-1) network, adds the integer ratio and registers a saturated modulus.
module mash_ncl
  import ddsm_pkg::*;
#(
  parameter int P_INT_WIDTH = 8,
  parameter int P_STAGE_LAT = 1
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_en,
  input  logic [1:0]             i_order,
  input  logic [P_INT_WIDTH-1:0] i_int,
  input  logic                   i_q1,
  input  logic                   i_q2,
  input  logic                   i_q3,
  output logic [P_INT_WIDTH-1:0] o_div,
  output logic                   o_valid,
  output logic                   o_sat
);

  localparam int FILL    = 2 * P_STAGE_LAT + 2;
  localparam int CNT_W   = $clog2(FILL + 1);
  localparam int S_WIDTH = P_INT_WIDTH + 2;
  localparam int MAX_DIV = (1 << P_INT_WIDTH) - 1;

  logic a1, a2, a2d, a3d, a3dd;
  logic [CNT_W-1:0] fill_cnt, fill_next;
  order_e order;
  logic signed [Y_WIDTH-1:0] y;
  logic signed [S_WIDTH-1:0] s;

  ddsm_delay #(.DEPTH(2 * P_STAGE_LAT)) u_align_a1 (
    .i_clk(i_clk), .i_rst(i_rst), .i_en(i_en), .i_d(i_q1), .o_q(a1)
  );

  ddsm_delay #(.DEPTH(P_STAGE_LAT)) u_align_a2 (
    .i_clk(i_clk), .i_rst(i_rst), .i_en(i_en), .i_d(i_q2), .o_q(a2)
  );

  // NOTE: y is assigned before any conditional update so no path leaves it
  // unassigned; that keeps this block purely combinational.
  always_comb begin
    order = decode_order(i_order);
    y = Y_WIDTH'(a1);
    if (order != ORDER_1) y = y + Y_WIDTH'(a2) - Y_WIDTH'(a2d);
    if (order == ORDER_3) y = y + Y_WIDTH'(i_q3) - Y_WIDTH'({a3d, 1'b0}) + Y_WIDTH'(a3dd);
    s = $signed({2'b00, i_int}) + $signed({{(S_WIDTH - Y_WIDTH){y[Y_WIDTH-1]}}, y});
    fill_next = (fill_cnt == CNT_W'(FILL)) ? fill_cnt : fill_cnt + 1'b1;
  end

  // NOTE: all state updates use non-blocking assignments so every register
  // samples pre-edge values, e.g. a3dd picks up the old a3d, not the new one.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      a2d      <= 1'b0;
      a3d      <= 1'b0;
      a3dd     <= 1'b0;
      fill_cnt <= '0;
      o_div    <= '0;
      o_sat    <= 1'b0;
      o_valid  <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      if (i_en) begin
        a2d      <= a2;
        a3d      <= i_q3;
        a3dd     <= a3d;
        fill_cnt <= fill_next;
        o_div    <= P_INT_WIDTH'(clamp_div(int'(s), MAX_DIV));
        o_sat    <= is_sat(int'(s), MAX_DIV);
        o_valid  <= (fill_next == CNT_W'(FILL));
      end
    end
  end

endmodule

// File: tb/tb_mash_ncl.sv
// Directed table-driven bench for mash_ncl with L = 1, 8-bit modulus.
module tb_mash_ncl;

  logic       clk = 1'b0;
  logic       rst, en, q1, q2, q3;
  logic [1:0] order;
  logic [7:0] int_v;
  logic [7:0] div;
  logic       valid, sat;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic       rst;
    logic       en;
    logic [1:0] order;
    logic [7:0] int_v;
    logic       q1, q2, q3;
    logic [7:0] div;
    logic       valid;
    logic       sat;
  } vec_t;

  vec_t vecs[$];

  mash_ncl #(.P_INT_WIDTH(8), .P_STAGE_LAT(1)) dut (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_order(order), .i_int(int_v),
    .i_q1(q1), .i_q2(q2), .i_q3(q3),
    .o_div(div), .o_valid(valid), .o_sat(sat)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic e, input logic [1:0] o, input logic [7:0] iv,
                     input logic a, input logic b, input logic c,
                     input logic [7:0] d, input logic v, input logic st);
    vec_t t;
    t.rst = r; t.en = e; t.order = o; t.int_v = iv;
    t.q1 = a; t.q2 = b; t.q3 = c;
    t.div = d; t.valid = v; t.sat = st;
    vecs.push_back(t);
  endtask

  task automatic drive(input logic r, input logic e, input logic [1:0] o, input logic [7:0] iv,
                       input logic a, input logic b, input logic c);
    rst = r; en = e; order = o; int_v = iv; q1 = a; q2 = b; q3 = c;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic [7:0] d, input logic v, input logic st);
    check({tag, " div"}, 32'(div), 32'(d));
    check({tag, " valid"}, 32'(valid), 32'(v));
    check({tag, " sat"}, 32'(sat), 32'(st));
  endtask

  initial begin
    //   rst en ord int  q1 q2 q3   div  vld sat
    add(1, 1, 3, 100, 0, 0, 0,    0,  0, 0);   // reset, en also high
    add(0, 1, 3, 100, 0, 0, 0,  100,  0, 0);   // fill 1
    add(0, 1, 3, 100, 0, 0, 0,  100,  0, 0);
    add(0, 1, 3, 100, 0, 0, 0,  100,  0, 0);
    add(0, 1, 3, 100, 0, 0, 0,  100,  1, 0);   // 4th sample -> first valid
    add(0, 1, 3, 100, 0, 0, 0,  100,  1, 0);
    add(0, 1, 3, 100, 0, 0, 1,  101,  1, 0);   // q3 pulse: +1
    add(0, 1, 3, 100, 0, 0, 0,   98,  1, 0);   // -2
    add(0, 1, 3, 100, 0, 0, 0,  101,  1, 0);   // +1
    add(0, 1, 3, 100, 0, 0, 0,  100,  1, 0);
    add(0, 1, 1, 100, 1, 0, 0,  100,  1, 0);   // q1 on, 2-sample alignment
    add(0, 1, 1, 100, 1, 0, 0,  100,  1, 0);
    add(0, 1, 1, 100, 1, 0, 0,  101,  1, 0);
    add(0, 1, 1, 100, 1, 0, 0,  101,  1, 0);
    add(0, 1, 1, 100, 0, 0, 0,  101,  1, 0);   // q1 off, drains
    add(0, 1, 1, 100, 0, 0, 0,  101,  1, 0);
    add(0, 1, 1, 100, 0, 0, 0,  100,  1, 0);
    add(0, 1, 2, 100, 0, 1, 0,  100,  1, 0);   // q2 pulse, 1-sample alignment
    add(0, 1, 2, 100, 0, 0, 0,  101,  1, 0);
    add(0, 1, 2, 100, 0, 0, 0,   99,  1, 0);
    add(0, 1, 2, 100, 0, 0, 0,  100,  1, 0);
    add(0, 1, 3,   0, 0, 0, 1,    1,  1, 0);   // low clamp
    add(0, 1, 3,   0, 0, 0, 0,    0,  1, 1);   // s = -2
    add(0, 1, 3,   0, 0, 0, 0,    1,  1, 0);
    add(0, 1, 3,   0, 0, 0, 0,    0,  1, 0);   // s = 0 exact, no clamp
    add(0, 1, 1, 255, 1, 0, 0,  255,  1, 0);   // high clamp
    add(0, 1, 1, 255, 1, 0, 0,  255,  1, 0);
    add(0, 1, 1, 255, 1, 0, 0,  255,  1, 1);   // s = 256
    add(0, 1, 0, 255, 1, 0, 0,  255,  1, 1);   // order 0 acts as 1
    add(0, 1, 0, 200, 1, 0, 0,  201,  1, 0);
    add(1, 1, 1, 200, 1, 0, 0,    0,  0, 0);   // mid-stream reset
    add(0, 1, 1, 200, 1, 0, 0,  200,  0, 0);   // delay line was cleared
    add(0, 1, 1, 200, 1, 0, 0,  200,  0, 0);
    add(0, 1, 1, 200, 1, 0, 0,  201,  0, 0);
    add(0, 1, 1, 200, 1, 0, 0,  201,  1, 0);   // refilled after 4 samples

    drive(1, 0, 3, 100, 0, 0, 0);
    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].en, vecs[i].order, vecs[i].int_v,
            vecs[i].q1, vecs[i].q2, vecs[i].q3);
      tick();
      check_out($sformatf("row%0d", i), vecs[i].div, vecs[i].valid, vecs[i].sat);
    end

    // Enable gap in the middle of an order-3 pulse response.
    for (int k = 0; k < 3; k++) begin
      drive(0, 1, 3, 100, 0, 0, 0);
      tick();
    end
    check_out("flush", 8'd100, 1'b1, 1'b0);
    drive(0, 1, 3, 100, 0, 0, 1);
    tick();
    check_out("gap pulse", 8'd101, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 3, 100, 1, 1, 1);   // carries ignored while disabled
      tick();
      check_out($sformatf("gap hold%0d", k), 8'd101, 1'b0, 1'b0);
    end
    drive(0, 1, 3, 100, 0, 0, 0);
    tick();
    check_out("gap resume0", 8'd98, 1'b1, 1'b0);
    tick();
    check_out("gap resume1", 8'd101, 1'b1, 1'b0);
    tick();
    check_out("gap resume2", 8'd100, 1'b1, 1'b0);

    // Saturation flag holds across a disabled cycle.
    drive(0, 1, 1, 255, 1, 0, 0);
    for (int k = 0; k < 3; k++) tick();
    check_out("sat run", 8'd255, 1'b1, 1'b1);
    drive(0, 0, 1, 0, 0, 0, 0);
    tick();
    check_out("sat hold", 8'd255, 1'b0, 1'b1);

    // Reset with enable low still clears everything.
    drive(1, 0, 1, 255, 1, 0, 0);
    tick();
    check_out("rst no en", 8'd0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
